// File: rtl/shift_reg_311_pkg.sv
// shift_reg_311_pkg: shared definitions for the shift_reg_311 block.
//   - MODE_* : encodings of the 2-bit mode_311 operation select
//   - state_e: burst controller FSM state type
package shift_reg_311_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/shift_ctrl_311.sv
// shift_ctrl_311: burst controller for shift_reg_311.
// Decodes the per-cycle datapath operation and runs the IDLE/SHIFT/DONE burst FSM with its
// remaining-shift counter.
// Ports:
//   clk, reset_311      clock, asynchronous active-high reset
//   mode, start, cnt    operation select, burst request, burst length
//   shift_en            shift the datapath register this edge
//   shift_left          shift direction when shift_en is high (1 = left)
//   load_en             load parallel data this edge
//   busy, done          registered status flags (SHIFT state / one-cycle completion)
module shift_ctrl_311
  import shift_reg_311_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_311,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic             shift_en,
  output logic             shift_left,
  output logic             load_en,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             burst_req;

  // Only shift modes can launch a burst; start with hold/load falls through to the mode.
  assign burst_req = start && ((mode == MODE_SHR) || (mode == MODE_SHL));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    shift_en   = 1'b0;
    shift_left = 1'b0;
    load_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (burst_req) begin
          // Launch edge: latch parameters only, the register is left untouched.
          dir_d   = (mode == MODE_SHL);
          cnt_d   = cnt;
          state_d = (cnt != '0) ? StShift : StDone;
        end else begin
          unique case (mode)
            MODE_HOLD: ;
            MODE_SHR:  shift_en = 1'b1;
            MODE_SHL: begin
              shift_en   = 1'b1;
              shift_left = 1'b1;
            end
            MODE_LOAD: load_en = 1'b1;
            default: ;
          endcase
        end
      end
      StShift: begin
        shift_en   = 1'b1;
        shift_left = dir_q;
        // cnt_q is at least 1 here, so the decrement never wraps.
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset_311) begin
    if (reset_311) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/shift_reg_311.sv
// shift_reg_311: universal shift register with hold/shift/load modes and counted burst shifts.
// Optional feature macro: SHIFT_REG_311_ROTATE_EN adds rot_311, which makes every shift
// recirculate the outgoing bit instead of taking the serial input.
// Ports:
//   clk, reset_311          clock, asynchronous active-high reset
//   mode_311                00 hold, 01 shift right, 10 shift left, 11 load
//   d_311                   parallel load data
//   sin_r_311, sin_l_311    serial inputs for right (into MSB) / left (into LSB) shifts
//   start_311, cnt_311      burst request and burst shift count
//   rot_311                 rotate enable (only with SHIFT_REG_311_ROTATE_EN)
//   q_311, qb_311           register contents and its complement
//   busy_311, done_311      burst in progress / one-cycle burst completion
module shift_reg_311
  import shift_reg_311_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_311,
  input  logic [1:0]       mode_311,
  input  logic [WIDTH-1:0] d_311,
  input  logic             sin_r_311,
  input  logic             sin_l_311,
  input  logic             start_311,
  input  logic [CNT_W-1:0] cnt_311,
`ifdef SHIFT_REG_311_ROTATE_EN
  input  logic             rot_311,
`endif
  output logic [WIDTH-1:0] q_311,
  output logic [WIDTH-1:0] qb_311,
  output logic             busy_311,
  output logic             done_311
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_en, shift_left, load_en;
  logic             in_r, in_l;

  shift_ctrl_311 #(
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .reset_311 (reset_311),
    .mode      (mode_311),
    .start     (start_311),
    .cnt       (cnt_311),
    .shift_en  (shift_en),
    .shift_left(shift_left),
    .load_en   (load_en),
    .busy      (busy_311),
    .done      (done_311)
  );

`ifdef SHIFT_REG_311_ROTATE_EN
  // Rotation feeds the bit leaving one end back into the other.
  assign in_r = rot_311 ? q_q[0]       : sin_r_311;
  assign in_l = rot_311 ? q_q[WIDTH-1] : sin_l_311;
`else
  assign in_r = sin_r_311;
  assign in_l = sin_l_311;
`endif

  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = d_311;
    end else if (shift_en) begin
      if (shift_left) begin
        q_d = {q_q[WIDTH-2:0], in_l};
      end else begin
        q_d = {in_r, q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset_311) begin
    if (reset_311) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_311  = q_q;
  assign qb_311 = ~q_q;

endmodule

// File: tb/tb_shift_reg_311.sv
// tb_shift_reg_311: directed scoreboard bench for shift_reg_311 (WIDTH=8, CNT_W=4).
// Stimulus pushes the expected post-edge state; a monitor pops and compares after each
// rising edge, or right away for asynchronous reset checks.
module tb_shift_reg_311;

  logic       clk = 1'b0;
  logic       reset_311 = 1'b1;
  logic [1:0] mode_311 = 2'b00;
  logic [7:0] d_311 = 8'h00;
  logic       sin_r_311 = 1'b0;
  logic       sin_l_311 = 1'b0;
  logic       start_311 = 1'b0;
  logic [3:0] cnt_311 = 4'd0;
  logic       rot_311 = 1'b0;
  logic [7:0] q_311, qb_311;
  logic       busy_311, done_311;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];
  event async_ev;

  always #5 clk = ~clk;

  shift_reg_311 #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .reset_311(reset_311),
    .mode_311 (mode_311),
    .d_311    (d_311),
    .sin_r_311(sin_r_311),
    .sin_l_311(sin_l_311),
    .start_311(start_311),
    .cnt_311  (cnt_311),
`ifdef SHIFT_REG_311_ROTATE_EN
    .rot_311  (rot_311),
`endif
    .q_311    (q_311),
    .qb_311   (qb_311),
    .busy_311 (busy_311),
    .done_311 (done_311)
  );

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({q_311, qb_311, busy_311, done_311} !== {e.q, ~e.q, e.busy, e.done}) begin
          errors++;
          $display("FAIL %s: got q=%h qb=%h busy=%b done=%b, expected q=%h qb=%h busy=%b done=%b",
                   e.name, q_311, qb_311, busy_311, done_311, e.q, ~e.q, e.busy, e.done);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [7:0] q, input logic busy, input logic done,
                              input string name);
    exp_t e;
    e.q = q;
    e.busy = busy;
    e.done = done;
    e.name = name;
    return e;
  endfunction

  // Drive inputs for the next edge and record the state expected after it.
  task automatic step(input logic [1:0] mode, input logic [7:0] d, input logic sr,
                      input logic sl, input logic st, input logic [3:0] cnt,
                      input logic [7:0] eq, input logic eb, input logic ed, input string name);
    @(negedge clk);
    mode_311  = mode;
    d_311     = d;
    sin_r_311 = sr;
    sin_l_311 = sl;
    start_311 = st;
    cnt_311   = cnt;
    sb.push_back(mk(eq, eb, ed, name));
  endtask

  task automatic assert_reset(input string name);
    @(negedge clk);
    reset_311 = 1'b1;
    start_311 = 1'b0;
    mode_311  = 2'b00;
    sb.push_back(mk(8'h00, 1'b0, 1'b0, name));
    -> async_ev;
    @(negedge clk);
    reset_311 = 1'b0;
  endtask

  initial begin
    logic [7:0] ff;
    logic [7:0] eq;
    ff = 8'hFF;

    // Asynchronous reset, before any edge has been seen with reset released.
    #1;
    sb.push_back(mk(8'h00, 1'b0, 1'b0, "reset_async"));
    -> async_ev;
    @(negedge clk);
    reset_311 = 1'b0;

    // Load and hold
    step(2'b11, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0, "load_a5");
    for (int i = 0; i < 3; i++) step(2'b00, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 0, "hold_a5");

    // Single shifts
    step(2'b11, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "load_00");
    step(2'b01, 8'h00, 1, 0, 0, 0, 8'h80, 0, 0, "shr_1");
    step(2'b01, 8'h00, 1, 0, 0, 0, 8'hC0, 0, 0, "shr_2");
    step(2'b10, 8'h00, 0, 1, 0, 0, 8'h81, 0, 0, "shl_1");

    // Left burst of 3; inputs during SHIFT are junk and must be ignored.
    step(2'b10, 8'h00, 0, 0, 1, 3, 8'h81, 1, 0, "burst_l_launch");
    step(2'b11, 8'hFF, 0, 0, 1, 9, 8'h02, 1, 0, "burst_l_e1");
    step(2'b11, 8'hFF, 0, 0, 1, 9, 8'h04, 1, 0, "burst_l_e2");
    step(2'b11, 8'hFF, 0, 0, 1, 9, 8'h08, 0, 1, "burst_l_done");
    step(2'b10, 8'h00, 0, 1, 1, 2, 8'h08, 0, 0, "done_ignores_start");
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'h08, 0, 0, "burst_l_idle");

    // Zero-length burst
    step(2'b10, 8'h00, 0, 1, 1, 0, 8'h08, 0, 1, "burst_cnt0_done");
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'h08, 0, 0, "burst_cnt0_idle");

    // start with load mode is ignored
    step(2'b11, 8'h3C, 0, 0, 1, 2, 8'h3C, 0, 0, "start_load_ignored");
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0, "start_load_idle");

    // Right burst of 2, serial input sampled per edge
    step(2'b01, 8'h00, 0, 0, 1, 2, 8'h3C, 1, 0, "burst_r_launch");
    step(2'b00, 8'h00, 1, 0, 0, 0, 8'h9E, 1, 0, "burst_r_e1");
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'h4F, 0, 1, "burst_r_done");
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'h4F, 0, 0, "burst_r_idle");

    // Reset in the middle of a 5-shift burst
    step(2'b10, 8'h00, 0, 1, 1, 5, 8'h4F, 1, 0, "mid_launch");
    step(2'b00, 8'h00, 0, 1, 0, 0, 8'h9F, 1, 0, "mid_e1");
    step(2'b00, 8'h00, 0, 1, 0, 0, 8'h3F, 1, 0, "mid_e2");
    assert_reset("mid_reset");
    for (int i = 0; i < 4; i++) step(2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "mid_no_done");
    step(2'b01, 8'h00, 1, 0, 0, 0, 8'h80, 0, 0, "post_reset_idle");

    // Maximum count: 15 right shifts with sin_r=1, counter must not wrap.
    step(2'b11, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "max_load");
    step(2'b01, 8'h00, 1, 0, 1, 15, 8'h00, 1, 0, "max_launch");
    for (int i = 1; i <= 15; i++) begin
      eq = (i >= 8) ? 8'hFF : ~(ff >> i);
      step(2'b00, 8'h00, 1, 0, 0, 0, eq, (i < 15), (i == 15), $sformatf("max_e%0d", i));
    end
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0, "max_idle");

`ifdef SHIFT_REG_311_ROTATE_EN
    step(2'b11, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0, "rot_load");
    @(negedge clk);
    rot_311 = 1'b1;
    step(2'b10, 8'h00, 0, 0, 0, 0, 8'h03, 0, 0, "rot_shl");
    step(2'b11, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0, "rot_reload");
    step(2'b01, 8'h00, 0, 0, 1, 1, 8'h81, 1, 0, "rot_burst_launch");
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'hC0, 0, 1, "rot_burst_done");
    step(2'b00, 8'h00, 0, 0, 0, 0, 8'hC0, 0, 0, "rot_burst_idle");
`endif

    repeat (3) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
